// File: rtl/wb_burst_master.sv
// Wishbone B4 pipelined burst initiator: one command becomes len single-word beats, first strobe two cycles after accept.
// Outstanding beats are capped at MAX_OUTSTANDING; stall holds the presented beat; the write stream is popped only on a beat load.
module wb_burst_master #(
  parameter int AW              = 24,
  parameter int DW              = 16,
  parameter int LENW            = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [LENW-1:0] cmd_len,
  input  logic            wdata_valid,
  output logic            wdata_ready,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wdata_sel,
  output logic            rdata_valid,
  output logic [DW-1:0]   rdata,
  output logic            done,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_stall_i
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]      state;
  logic [AW-1:0]   next_adr;
  logic [LENW-1:0] remaining;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   outstanding_next;
  logic            accept;
  logic            ack_ok;
  logic            load;
  logic            beat_pending;

  assign cmd_ready = (state == S_IDLE);
  assign accept    = wb_stb_o & ~wb_stall_i;
  // Acks with nothing in flight are stray and must not underflow the counter.
  assign ack_ok    = wb_ack_i & (outstanding != '0);

  always_comb begin
    outstanding_next = outstanding;
    if (accept && !ack_ok)
      outstanding_next = outstanding + OW'(1);
    else if (!accept && ack_ok)
      outstanding_next = outstanding - OW'(1);
  end

  assign load = (state == S_ISSUE) && (!wb_stb_o || accept) && (remaining != '0)
              && (outstanding_next < OUT_MAX) && (!wb_we_o || wdata_valid);

  assign beat_pending = wb_stb_o && !accept;
  assign wdata_ready  = load & wb_we_o;
  assign rdata_valid  = ack_ok & ~wb_we_o;
  assign rdata        = wb_dat_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      next_adr    <= '0;
      remaining   <= '0;
      outstanding <= '0;
      done        <= 1'b0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      wb_sel_o    <= '0;
    end else begin
      done        <= 1'b0;
      outstanding <= outstanding_next;

      if (load) begin
        wb_stb_o  <= 1'b1;
        wb_adr_o  <= next_adr;
        next_adr  <= next_adr + AW'(1);
        remaining <= remaining - LENW'(1);
        if (wb_we_o) begin
          wb_dat_o <= wdata;
          wb_sel_o <= wdata_sel;
        end else begin
          wb_sel_o <= '1;
        end
      end else if (accept) begin
        wb_stb_o <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            next_adr  <= cmd_addr;
            remaining <= cmd_len;
            wb_we_o   <= cmd_write;
            if (cmd_len == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state    <= S_ISSUE;
              wb_cyc_o <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (remaining == '0 && !beat_pending) begin
            if (outstanding_next == '0) begin
              state    <= S_DONE;
              wb_cyc_o <= 1'b0;
              done     <= 1'b1;
            end else begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (outstanding_next == '0) begin
            state    <= S_DONE;
            wb_cyc_o <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          wb_we_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master: a table of bursts against a latency-programmable slave, plus reset corner sequences.
module tb_wb_burst_master;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [23:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [15:0] wdata;
  logic [1:0]  wdata_sel;
  logic        rdata_valid;
  logic [15:0] rdata;
  logic        done;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [23:0] wb_adr_o;
  logic [15:0] wb_dat_o;
  logic [1:0]  wb_sel_o;
  logic [15:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_stall_i;

  wb_burst_master #(.AW(24), .DW(16), .LENW(8), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata), .wdata_sel(wdata_sel),
    .rdata_valid(rdata_valid), .rdata(rdata), .done(done),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [23:0] addr;
    logic [7:0]  len;
    int          lat;
    int          stall_beat;
    int          stall_cyc;
    int          gap_beat;
    int          gap_cyc;
    bit          sel_vary;
    int          exp_done;
    int          exp_max;
  } vec_t;

  vec_t vecs[8];
  int   n_vec = 0;
  int   n_bad = 0;
  int   due_q[$];
  logic [15:0] rd_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] wpat(input int k);
    logic [15:0] m;
    m = 16'(k + 1);
    return 16'h1111 * m;
  endfunction

  function automatic logic [1:0] spat(input bit vary, input int k);
    if (!vary) return 2'b11;
    return (k % 2 == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [15:0] rexp(input logic [23:0] a);
    return a[15:0] ^ 16'h5A3C ^ {8'h00, a[23:16]};
  endfunction

  task automatic run_burst(input vec_t v);
    int t, acc, pops, gap_cnt, stall_cnt, rcnt, outs, maxo, cyc_hi, done_t, tmp_i;
    logic [23:0] ea, hold_adr;
    logic [15:0] hold_dat, tmp_d;
    logic [1:0]  hold_sel;
    due_q.delete();
    rd_q.delete();
    acc = 0; pops = 0; gap_cnt = 0; stall_cnt = 0; rcnt = 0;
    outs = 0; maxo = 0; cyc_hi = 0; done_t = -1;
    hold_adr = '0; hold_dat = '0; hold_sel = '0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len;
    #1;
    chk("cmd_ready_idle", cmd_ready, 1);
    t = 0;
    while (done_t < 0 && t < 400) begin
      @(posedge clk); #1;
      t++;
      cmd_valid = 1'b0;
      if (due_q.size() > 0 && due_q[0] == t) begin
        wb_ack_i = 1'b1; wb_dat_i = rd_q[0];
      end else begin
        wb_ack_i = 1'b0; wb_dat_i = 16'h0000;
      end
      wb_stall_i  = wb_stb_o && (acc == v.stall_beat) && (stall_cnt < v.stall_cyc);
      wdata_valid = v.wr && (pops < int'(v.len)) && !(pops == v.gap_beat && gap_cnt < v.gap_cyc);
      wdata       = wpat(pops);
      wdata_sel   = spat(v.sel_vary, pops);
      #1;
      if (wb_cyc_o) cyc_hi++;
      if (done) begin
        done_t = t;
        chk("cyc_low_at_done", wb_cyc_o, 0);
        chk("cmd_ready_low_at_done", cmd_ready, 0);
      end
      if (wb_ack_i) begin
        tmp_i = due_q.pop_front();
        tmp_d = rd_q.pop_front();
        if (outs > 0) outs--;
      end
      if (rdata_valid) begin
        ea = v.addr + 24'(rcnt);
        chk("rdata_order", rdata, rexp(ea));
        rcnt++;
      end
      if (wb_stall_i) begin
        if (stall_cnt == 0) begin
          hold_adr = wb_adr_o; hold_dat = wb_dat_o; hold_sel = wb_sel_o;
        end else begin
          chk("stall_hold_stb", wb_stb_o, 1);
          chk("stall_hold_adr", wb_adr_o, hold_adr);
          chk("stall_hold_dat", wb_dat_o, hold_dat);
          chk("stall_hold_sel", wb_sel_o, hold_sel);
        end
        chk("stall_wdata_ready", wdata_ready, 0);
        stall_cnt++;
      end
      if (!wdata_valid && pops == v.gap_beat) gap_cnt++;
      if (wdata_ready) pops++;
      if (wb_stb_o && !wb_stall_i) begin
        ea = v.addr + 24'(acc);
        chk("beat_adr", wb_adr_o, ea);
        chk("beat_we", wb_we_o, v.wr);
        if (v.wr) begin
          chk("beat_dat", wb_dat_o, wpat(acc));
          chk("beat_sel", wb_sel_o, spat(v.sel_vary, acc));
        end else begin
          chk("beat_sel_rd", wb_sel_o, 2'b11);
        end
        due_q.push_back(t + v.lat);
        rd_q.push_back(rexp(wb_adr_o));
        acc++;
        outs++;
      end
      if (outs > maxo) maxo = outs;
    end
    wb_ack_i = 1'b0; wb_stall_i = 1'b0; wdata_valid = 1'b0;
    if (done_t < 0) chk("done_timeout", 0, 1);
    chk("done_cycle", done_t, v.exp_done);
    chk("accept_count", acc, v.len);
    chk("wdata_pops", pops, v.wr ? int'(v.len) : 0);
    chk("rdata_count", rcnt, v.wr ? 0 : int'(v.len));
    chk("max_outstanding", maxo, v.exp_max);
    chk("cyc_high_cycles", cyc_hi, v.exp_done - 1);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("cmd_ready_after", cmd_ready, 1);
    chk("cyc_after", wb_cyc_o, 0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 24'h000100, 8'd4, 1, -1, 0, -1, 0, 1'b0, 7, 1};
    vecs[1] = '{1'b0, 24'h000400, 8'd8, 6, -1, 0, -1, 0, 1'b0, 19, 4};
    vecs[2] = '{1'b1, 24'h000020, 8'd4, 1, 1, 3, -1, 0, 1'b0, 10, 1};
    vecs[3] = '{1'b1, 24'h000300, 8'd3, 1, -1, 0, 1, 2, 1'b0, 8, 1};
    vecs[4] = '{1'b0, 24'hFFFFFE, 8'd4, 1, -1, 0, -1, 0, 1'b0, 7, 1};
    vecs[5] = '{1'b1, 24'h000ABC, 8'd5, 3, -1, 0, -1, 0, 1'b1, 10, 3};
    vecs[6] = '{1'b0, 24'h000055, 8'd0, 1, -1, 0, -1, 0, 1'b0, 1, 0};
    vecs[7] = '{1'b0, 24'h000010, 8'd2, 1, -1, 0, -1, 0, 1'b0, 5, 1};

    rst_n = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 24'h000777; cmd_len = 8'd4;
    wdata_valid = 1'b0; wdata = '0; wdata_sel = '0;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_stall_i = 1'b0;

    // Command held during reset must not be taken.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_we", wb_we_o, 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_sel", wb_sel_o, 0);
    chk("rst_done", done, 0);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_cyc", wb_cyc_o, 0);

    for (int i = 0; i < 7; i++) run_burst(vecs[i]);

    // Reset while the third beat of a read burst is on the bus.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 24'h000200; cmd_len = 8'd8;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end
    chk("mid_beat3_stb", wb_stb_o, 1);
    chk("mid_beat3_adr", wb_adr_o, 24'h000202);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_cyc", wb_cyc_o, 0);
    chk("mid_rst_stb", wb_stb_o, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    wb_ack_i = 1'b1; wb_dat_i = 16'hBEEF;
    #1;
    chk("stray_ack_rdata_valid", rdata_valid, 0);
    @(posedge clk); #1;
    wb_ack_i = 1'b0; wb_dat_i = 16'h0000;
    chk("stray_ack_cyc", wb_cyc_o, 0);
    chk("stray_ack_cmd_ready", cmd_ready, 1);

    run_burst(vecs[7]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
